// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
//
// Control FSM for a multi-cycle RV32I-subset datapath (lw, sw, R-type ALU,
// I-type ALU, beq/bne, jal, jalr, lui). One instruction is walked through
// FETCH, DECODE and then a short opcode-specific sequence of states. All
// datapath selects are decoded from the current state only (Moore). PCWrite
// also folds in the branch-taken term while in BRANCH.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous reset, active low
//   opcode       in   7  Instr[6:0]
//   funct3       in   3  Instr[14:12]
//   funct7       in   7  Instr[31:25]
//   Zero         in   1  ALU zero flag
//   PCWrite      out  1  PC write enable
//   IRWrite      out  1  instruction-register write enable
//   MemWrite     out  1  data memory write enable
//   RegWrite     out  1  register-file write enable
//   AdrSrc       out  1  memory address: 0=PC, 1=ALUOut
//   ALUSrcA      out  2  00=PC, 01=OldPC, 10=RS1
//   ALUSrcB      out  2  00=RS2, 01=ImmExt, 10=constant 4
//   ResultSrc    out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
//   ImmSrc       out  3  000=I, 001=S, 010=B, 011=J, 100=U
//   ALUControl   out  3  000=add, 001=sub, 010=and, 011=or, 101=slt
//   IllegalInstr out  1  pulse in DECODE on an unsupported opcode
//   state        out  4  current FSM state code
// -----------------------------------------------------------------------------
module multi_cycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       IllegalInstr,
   output logic [3:0] state
);

   // State codes are architecturally visible on the state port.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALRWB   = 4'd12,
      S_LUI      = 4'd13
   } state_e;

   // Supported opcodes
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRANCH= 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   // Select encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   state_e state_q;
   state_e state_d;

   logic pc_update_s;
   logic branch_s;
   logic irwrite_s;
   logic memwrite_s;
   logic regwrite_s;
   logic illegal_s;

   // True for every opcode the controller knows how to sequence.
   function automatic logic is_legal_op(input logic [6:0] op);
      logic ok;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_ITYPE,
         OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // ALU operation for R/I-type; funct7[5] only means sub on R-type, since
   // on I-type it is just immediate bits.
   function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       rtype);
      logic [2:0] op;
      case (f3)
         3'b000:  op = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // beq takes on Zero, bne on !Zero; other branch types are not supported
   // and simply fall through.
   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       z);
      logic t;
      case (f3)
         3'b000:  t = z;
         3'b001:  t = ~z;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_SW) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JALRWB;
         S_JALRWB:   state_d = S_FETCH;
         S_LUI:      state_d = S_FETCH;
         // Unused codes 14/15 recover to FETCH.
         default:    state_d = S_FETCH;
      endcase
   end

   // Per-state output decode; write enables are then masked while in reset.
   always_comb begin
      pc_update_s = 1'b0;
      branch_s    = 1'b0;
      irwrite_s   = 1'b0;
      memwrite_s  = 1'b0;
      regwrite_s  = 1'b0;
      illegal_s   = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      ResultSrc   = RES_ALUOUT;
      ImmSrc      = IMM_I;
      ALUControl  = ALU_ADD;

      case (state_q)
         S_FETCH: begin
            irwrite_s   = 1'b1;
            ALUSrcA     = SRCA_PC;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALURES;
            pc_update_s = 1'b1;
         end
         S_DECODE: begin
            // Precompute OldPC + imm as the branch/jal target.
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = (opcode == OP_JAL) ? IMM_J : IMM_B;
            illegal_s = ~is_legal_op(opcode);
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            regwrite_s = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            ResultSrc  = RES_ALUOUT;
            memwrite_s = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            ALUControl = alu_decode(funct3, funct7[5], 1'b1);
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = IMM_I;
            ALUControl = alu_decode(funct3, funct7[5], 1'b0);
         end
         S_ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            ALUControl = ALU_SUB;
            ResultSrc  = RES_ALUOUT;
            branch_s   = 1'b1;
         end
         S_JAL: begin
            // ALUOut already holds the target; OldPC+4 is the link value.
            ALUSrcA     = SRCA_OLDPC;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALUOUT;
            pc_update_s = 1'b1;
         end
         S_JALR: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_IMM;
            ImmSrc      = IMM_I;
            ResultSrc   = RES_ALURES;
            pc_update_s = 1'b1;
         end
         S_JALRWB: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURES;
            regwrite_s = 1'b1;
         end
         S_LUI: begin
            ImmSrc     = IMM_U;
            ResultSrc  = RES_IMM;
            regwrite_s = 1'b1;
         end
         default: begin
            illegal_s = 1'b0;
         end
      endcase

      // Reset is synchronous, so the current state still decodes while rst
      // is low; the enables must be masked combinationally.
      if (!rst) begin
         PCWrite      = 1'b0;
         IRWrite      = 1'b0;
         MemWrite     = 1'b0;
         RegWrite     = 1'b0;
         IllegalInstr = 1'b0;
      end else begin
         PCWrite      = pc_update_s | (branch_s & branch_taken(funct3, Zero));
         IRWrite      = irwrite_s;
         MemWrite     = memwrite_s;
         RegWrite     = regwrite_s;
         IllegalInstr = illegal_s;
      end
   end

   assign state = state_q;

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst, with rst sampled only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous reset, active low.
REQ-004 opcode, funct3, funct7  input  7/3/7  fields of the instruction-register output (Instr[6:0], [14:12], [31:25]).
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-007 AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 ALUSrcA  output  2  00=PC, 01=OldPC, 10=RS1 register.
REQ-009 ALUSrcB  output  2  00=RS2 register, 01=ImmExt, 10=constant 4.
REQ-010 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
REQ-011 ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U.
REQ-012 ALUControl  output  3  000=add, 001=sub, 010=and, 011=or, 101=slt.
REQ-013 IllegalInstr  output  1  one-cycle pulse on an unsupported opcode; state  output  4  current FSM state.

Function
REQ-014 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALRWB=12, LUI=13; codes 14-15 go to FETCH on the next edge.
REQ-015 Outputs SHALL be Moore (decoded from state), except that PCWrite = PCUpdate | (Branch & taken).
REQ-016 Any output not listed for a state SHALL be 0.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1; next state DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, add; ImmSrc=J if the opcode is jal, else B.
REQ-019 DECODE next state by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI.
REQ-020 DECODE with any other opcode SHALL go to FETCH and raise IllegalInstr for that cycle.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=I for lw or S for sw; next state MEMREAD for lw or MEMWRITE for sw.
REQ-022 MEMREAD: AdrSrc=1, ResultSrc=00; next state MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-024 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; next state FETCH.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00, function decode; next state ALUWB.
REQ-026 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, function decode; next state ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-028 Function decode: funct3 000 selects add, or sub only when R-type with funct7[5]=1; 010 selects slt; 110 selects or; 111 selects and; any other funct3 selects add.
REQ-029 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1; next state FETCH.
REQ-030 Branch taken condition: Zero when funct3=000; !Zero when funct3=001; never taken for any other funct3.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1; next state ALUWB.
REQ-032 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add, ResultSrc=10, PCUpdate=1; next state JALRWB.
REQ-033 JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1; next state FETCH.
REQ-034 LUI: ImmSrc=U, ResultSrc=11, RegWrite=1; next state FETCH.
REQ-035 Latency in cycles, FETCH inclusive: lw 5; R, I, sw, jal and jalr 4; beq, bne and lui 3; illegal 2.

Reset
REQ-036 When rst=0 at a clock edge, state SHALL become FETCH regardless of the current state, abandoning any instruction in flight.
REQ-037 While rst=0, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr SHALL be forced to 0.
REQ-038 The first edge with rst=1 SHALL execute FETCH.

Verification
REQ-039 Release reset, opcode=0000011 -> state sequence 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in state 4.
REQ-040 opcode=0110011, funct3=000, funct7=0100000 -> ALUControl=001 in EXECR; RegWrite=1 in ALUWB; 4 cycles.
REQ-041 opcode=1100011, funct3=001, Zero=0 in BRANCH -> PCWrite=1; repeat with Zero=1 -> PCWrite=0.
REQ-042 opcode=1100111 -> PCWrite=1 with ResultSrc=10 in JALR, then RegWrite=1 with ALUSrcA=01, ALUSrcB=10 in JALRWB.
REQ-043 opcode=1111111 -> IllegalInstr=1 in DECODE, then FETCH; no write enable asserted except in FETCH.
REQ-044 Assert rst=0 during MEMWRITE -> MemWrite=0 in the same cycle, state=0 after the edge, no write enables while rst=0.
